// File: rtl/denorm_in_pkg.sv
`default_nettype none
// ============================================================================
// Module  : denorm_in_pkg
// Purpose : Shared definitions for the shift-add dividend reconstructor.
//           Holds the state encoding and the operand/result width helpers.
//           The divider uses the same width helpers.
// Ports   : (package, none)
// Rev     : 1.0  initial release
// ============================================================================
package denorm_in_pkg;

  // Two-state controller: idle/accepting, or iterating the shift-add loop
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  localparam int unsigned c_Q_W = 8;  // quotient / multiplier width

  // Divisor, remainder and multiplicand width for a given fraction width
  function automatic int unsigned opnd_w(input int unsigned s);
    return s + 8;
  endfunction

  // Reconstructed dividend / accumulator width for a given fraction width
  function automatic int unsigned wide_w(input int unsigned s);
    return s + 16;
  endfunction

endpackage : denorm_in_pkg
`default_nettype wire

// File: rtl/denorm_in_shift_add_step.sv
`default_nettype none
// ============================================================================
// Module  : shift_add_step
// Purpose : One combinational iteration of the unsigned shift-add multiply.
//           It conditionally adds the multiplicand into the accumulator on
//           the multiplier LSB, then advances both shift registers.
// Ports   : acc_i/acc_o  accumulator in / next
//           mc_i/mc_o    multiplicand in / next (shifted left by one)
//           qr_i/qr_o    multiplier in / next (shifted right by one)
// Rev     : 1.0  initial release
// ============================================================================
module shift_add_step
  import denorm_in_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0]     acc_i,
  input  logic [W-1:0]     mc_i,
  input  logic [c_Q_W-1:0] qr_i,
  output logic [W-1:0]     acc_o,
  output logic [W-1:0]     mc_o,
  output logic [c_Q_W-1:0] qr_o
);

  // The accumulator is sized so the worst-case sum never carries out
  assign acc_o = qr_i[0] ? (acc_i + mc_i) : acc_i;
  assign mc_o  = mc_i << 1;
  assign qr_o  = qr_i >> 1;

endmodule : shift_add_step
`default_nettype wire

// File: rtl/denorm_in.sv
`default_nettype none
// ============================================================================
// Module  : denorm_in
// Purpose : Sequential shift-add reconstructor. It computes
//           dividend = Q*M + R over exactly D iterations. It is the inverse
//           of the non-restoring divider and uses the same en/start/ready
//           handshake.
// Ports   : MHz10       system clock, rising edge
//           rst         asynchronous active-high reset
//           en          block enable; low freezes all state, forces ready=0
//           start       request, sampled only while ready
//           Q_i[7:0]    quotient (bits [D-1:0] used)
//           M_i[S+7:0]  divisor / multiplicand
//           R_i[S+7:0]  remainder
//           dividend_o  reconstructed dividend, held until next completion
//           valid       one-cycle pulse marking a new dividend_o
//           ready       en && idle (combinational)
// Rev     : 1.0  initial release
// ============================================================================
module denorm_in
  import denorm_in_pkg::*;
#(
  parameter int unsigned S = 8,
  parameter int unsigned D = 8
) (
  input  logic                    MHz10,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic [c_Q_W-1:0]        Q_i,
  input  logic [opnd_w(S)-1:0]    M_i,
  input  logic [opnd_w(S)-1:0]    R_i,
  output logic [wide_w(S)-1:0]    dividend_o,
  output logic                    valid,
  output logic                    ready
);

  localparam int unsigned c_OP_W   = opnd_w(S);
  localparam int unsigned c_WIDE_W = wide_w(S);
  localparam int unsigned c_EXT_W  = c_WIDE_W - c_OP_W;

  state_t                state_q, state_d;
  logic [c_WIDE_W-1:0]   acc_q, acc_d;
  logic [c_WIDE_W-1:0]   mc_q, mc_d;
  logic [c_Q_W-1:0]      qr_q, qr_d;
  logic [3:0]            i_q, i_d;
  logic [c_WIDE_W-1:0]   dividend_q, dividend_d;
  logic                  valid_q, valid_d;

  logic [c_WIDE_W-1:0]   step_acc;
  logic [c_WIDE_W-1:0]   step_mc;
  logic [c_Q_W-1:0]      step_qr;

  shift_add_step #(
    .W (c_WIDE_W)
  ) u_step (
    .acc_i (acc_q),
    .mc_i  (mc_q),
    .qr_i  (qr_q),
    .acc_o (step_acc),
    .mc_o  (step_mc),
    .qr_o  (step_qr)
  );

  assign ready = en && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mc_d       = mc_q;
    qr_d       = qr_q;
    i_d        = i_q;
    dividend_d = dividend_q;
    // The valid pulse drops on the next edge even while en is low
    valid_d    = 1'b0;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_d   = {{c_EXT_W{1'b0}}, R_i};
            mc_d    = {{c_EXT_W{1'b0}}, M_i};
            qr_d    = Q_i;
            i_d     = 4'(D);
            state_d = MULT;
          end
        end
        MULT: begin
          acc_d = step_acc;
          mc_d  = step_mc;
          qr_d  = step_qr;
          i_d   = i_q - 4'd1;
          // The iteration count is fixed, with no early exit on QR==0, so
          // latency does not depend on the data
          if (i_q == 4'd1) begin
            dividend_d = step_acc;
            valid_d    = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mc_q       <= '0;
      qr_q       <= '0;
      i_q        <= '0;
      dividend_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mc_q       <= mc_d;
      qr_q       <= qr_d;
      i_q        <= i_d;
      dividend_q <= dividend_d;
      valid_q    <= valid_d;
    end
  end

  assign dividend_o = dividend_q;
  assign valid      = valid_q;

endmodule : denorm_in
`default_nettype wire

// File: tb/tb_denorm_in.sv
`default_nettype none
// ============================================================================
// Module  : tb_denorm_in
// Purpose : Self-checking bench for denorm_in. Expected dividends are queued
//           when a request is driven and compared when valid is seen.
//           Handshake timing is checked cycle by cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_denorm_in;

  localparam int unsigned S  = 8;
  localparam int unsigned D  = 8;
  localparam int unsigned OW = S + 8;
  localparam int unsigned W  = S + 16;

  logic          MHz10 = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    Q_i   = '0;
  logic [OW-1:0] M_i   = '0;
  logic [OW-1:0] R_i   = '0;
  logic [W-1:0]  dividend_o;
  logic          valid;
  logic          ready;

  denorm_in #(.S(S), .D(D)) dut (
    .MHz10      (MHz10),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .Q_i        (Q_i),
    .M_i        (M_i),
    .R_i        (R_i),
    .dividend_o (dividend_o),
    .valid      (valid),
    .ready      (ready)
  );

  always #5 MHz10 = ~MHz10;

  int           n_chk   = 0;
  int           n_pass  = 0;
  int           n_valid = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest request
  always @(negedge MHz10) begin
    if (!rst && valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        check("dividend", dividend_o, mon_exp);
      end
    end
  end

  // Issues a request in the current cycle and waits for its valid pulse.
  task automatic run_op(input logic [7:0] q, input logic [OW-1:0] m,
                        input logic [OW-1:0] r, input logic [W-1:0] exp,
                        input bit chk_busy);
    int cyc;
    check("ready_at_start", ready, 1);
    Q_i = q; M_i = m; R_i = r; start = 1'b1;
    sb.push_back(exp);
    @(negedge MHz10);
    start = 1'b0;
    // Operands are latched; scrambling the inputs must not matter
    Q_i = 8'($urandom); M_i = OW'($urandom); R_i = OW'($urandom);
    cyc = 1;
    while (!valid && cyc < 40) begin
      if (chk_busy) check("ready_busy", ready, 0);
      @(negedge MHz10);
      cyc++;
    end
    check("latency", cyc, D + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            cyc;
    int            nv;
    longint        x, m, q, r;

    // Reset state
    repeat (2) @(negedge MHz10);
    check("rst_dividend", dividend_o, 0);
    check("rst_valid", valid, 0);
    check("rst_ready_en", ready, 1);
    en = 1'b0; #1;
    check("ready_en_low", ready, 0);
    en = 1'b1;
    rst = 1'b0;
    @(negedge MHz10);

    // Basic, extremes, zero quotient (back-to-back after the first)
    run_op(8'd12, 16'd25, 16'd7, 24'd307, 1'b1);
    run_op(8'd255, 16'hFFFF, 16'hFFFF, 24'hFFFF00, 1'b0);
    run_op(8'd0, 16'hABCD, 16'h0042, 24'h000042, 1'b0);

    // Enable stall of 3 cycles mid-MULT; start during the stall is ignored
    check("ready_stall_start", ready, 1);
    Q_i = 8'd100; M_i = 16'd300; R_i = 16'd17; start = 1'b1;
    sb.push_back(24'd30017);
    @(negedge MHz10); start = 1'b0; cyc = 1;
    repeat (2) begin @(negedge MHz10); cyc++; end
    en = 1'b0; start = 1'b1; Q_i = 8'd1; M_i = 16'd1; R_i = 16'd1;
    repeat (3) begin
      check("ready_stalled", ready, 0);
      check("valid_stalled", valid, 0);
      @(negedge MHz10); cyc++;
    end
    en = 1'b1; start = 1'b0;
    while (!valid && cyc < 40) begin @(negedge MHz10); cyc++; end
    check("stall_latency", cyc, D + 1 + 3);
    @(negedge MHz10);

    // Reset in the fourth MULT cycle: no partial result, then normal op
    Q_i = 8'd200; M_i = 16'd1000; R_i = 16'd5; start = 1'b1;
    sb.push_back(24'd200005);
    @(negedge MHz10); start = 1'b0; cyc = 1;
    repeat (3) begin @(negedge MHz10); cyc++; end
    rst = 1'b1; #1;
    check("midrst_dividend", dividend_o, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ready", ready, 1);
    void'(sb.pop_back());
    nv = n_valid;
    @(negedge MHz10); rst = 1'b0;
    repeat (12) @(negedge MHz10);
    check("no_valid_after_rst", n_valid, nv);
    run_op(8'd3, 16'd7, 16'd2, 24'd23, 1'b1);

    // Round trip: divide random dividends in the bench, rebuild in the DUT
    for (int k = 0; k < 8; k++) begin
      m = longint'($urandom_range(1, 65535));
      x = longint'($urandom_range(0, 255)) * m + longint'($urandom_range(0, 65535)) % m;
      q = x / m;
      r = x % m;
      run_op(8'(q), OW'(m), OW'(r), W'(x), 1'b0);
    end

    repeat (3) @(negedge MHz10);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_denorm_in
`default_nettype wire

// File: doc/denorm_in.md
# denorm_in

Sequential shift-add reconstructor that rebuilds the dividend from a quotient, divisor and remainder (dividend = Q*M + R). It is the inverse of the team's non-restoring divider (`norm_out`): it consumes the same S/D parameterisation and the same `en`/`start`/`ready` handshake. It sits on the return path, re-scaling normalised counts back to raw units, and doubles as a round-trip checker for the divider.

## Interface
- `S`, default 8: extra fraction width; the divisor, remainder and multiplicand are S+8 bits wide.
- `D`, default 8: number of quotient bits consumed, and the iteration count; legal range is 1..8.
- `MHz10`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: reset. Asynchronous, active-high.
- `en`  in  1: block enable. When low, all state is frozen and `ready` is 0.
- `start`  in  1: request. Sampled only while `ready` is 1.
- `Q_i`  in  8: quotient. Only bits [D-1:0] are used.
- `M_i`  in  S+8: divisor (multiplicand), unsigned.
- `R_i`  in  S+8: remainder, unsigned.
- `dividend_o`  out  S+16: reconstructed dividend. Registered; holds its value until the next completion.
- `valid`  out  1: one-cycle registered pulse marking a new `dividend_o`.
- `ready`  out  1: combinational; equals `en && state==IDLE`.

## Operation
- States: IDLE and MULT. Internal registers:
  - ACC[S+15:0]: accumulator.
  - MC[S+15:0]: multiplicand.
  - QR[7:0]: multiplier.
  - i[3:0]: iteration counter.
- **IDLE, `en` and `start` both 1:**
  - ACC <= R_i, MC <= zero-extended M_i, QR <= Q_i, i <= D.
  - Next state is MULT.
- **MULT, `en` 1, each cycle:**
  - If QR[0] is 1, ACC <= ACC + MC.
  - MC <= MC << 1, QR <= QR >> 1, i <= i - 1.
- **Completion:** on the cycle where i==1 in MULT:
  - dividend_o <= the final ACC, including that cycle's add.
  - valid <= 1.
  - Next state is IDLE.
- `valid` clears on the following edge unconditionally, independent of `en`.
- **Width rule:** the sum is unsigned and never overflows. The maximum is (2^8-1)(2^(S+8)-1) + 2^(S+8)-1 = 2^8(2^(S+8)-1), which is below 2^(S+16). No saturation logic is required.
- **Fixed iteration count:** no early termination when QR reaches 0; latency is always D iterations.
- **`start` while not ready** (in MULT, or with `en` low): ignored, not queued.
- **`en` low:**
  - In MULT: ACC, MC, QR, i and state all hold, and the operation resumes when `en` returns high.
  - In IDLE: `start` is ignored.
- **Inputs mid-operation:** changes to `Q_i`/`M_i`/`R_i` during MULT have no effect; the operands were latched at start.
- **Reset:** asserting `rst`, including mid-operation, immediately forces:
  - state to IDLE;
  - ACC, MC, QR, i, `dividend_o` and `valid` to 0.
  - No partial result is emitted.
- **Reset values:** `dividend_o`=0, `valid`=0; `ready`=1 whenever `en` is 1 after reset.

## Timing
- `start` accepted in cycle t (the edge ending t loads operands).
- MULT occupies cycles t+1 .. t+D, assuming `en` stays high.
- `dividend_o` is updated and `valid`=1 during cycle t+D+1. Total latency is D+1 cycles.
- `ready` is 1 in cycle t+D+1, so a new `start` there is accepted. Back-to-back throughput is one result per D+1 cycles.
- Each cycle with `en` low during MULT extends the latency by exactly 1.

## Structure
- Shared package holds:
  - state encoding: IDLE=0, MULT=1;
  - the widths `S+8` and `S+16`, also used by `norm_out`.
- One natural sub-module: `shift_add_step`. It is combinational and maps (ACC, MC, QR) to their next values. The FSM/counter stays in `denorm_in`.

## Test plan
- **Basic:** S=8, D=8, Q=12, M=25, R=7, start in cycle 0. Expect `dividend_o`=307 and `valid` pulse in cycle 9, with `ready` low in cycles 1-8.
- **Extremes:** Q=255, M=0xFFFF, R=0xFFFF. Expect `dividend_o`=0xFFFF00, with no overflow and 24-bit output correct.
- **Zero quotient:** Q=0, M=0xABCD, R=0x0042. Expect `dividend_o`=0x000042 after a full 9-cycle latency (no early exit).
- **Enable stall:** drop `en` for 3 cycles mid-MULT. Expect `valid` delayed by exactly 3 cycles and the result unchanged. `start` during the stall is ignored.
- **Reset mid-op:** assert `rst` in cycle 4 of MULT. Expect immediate `dividend_o`=0, `valid`=0, state IDLE, and no `valid` pulse afterwards. A new start then completes normally.
- **Back-to-back and round trip:**
  - Assert `start` in the `valid` cycle; the second result appears D+1 cycles later.
  - Random round-trip: feed `norm_out` quotient/remainder outputs through this block and expect the original dividend.
